// File: rtl/bool_test_pkg.sv
// Shared encodings for the boolean-unit sweep checker and its golden model.
package bool_test_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/bool_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker (master) and its environment (slave).
interface bool_sweep_checker_if
  import bool_test_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 13
);

  logic             start;
  op_e              op_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  logic [WIDTH-1:0] first_err_got;

  modport master (
    input  start, op_sel, dut_out,
    output a, b, busy, done, pass, err_count, first_err_a, first_err_b, first_err_got
  );

  modport slave (
    output start, op_sel, dut_out,
    input  a, b, busy, done, pass, err_count, first_err_a, first_err_b, first_err_got
  );

endinterface

// File: rtl/bool_golden.sv
// Combinational reference for 2-input WIDTH-bit boolean units.
module bool_golden
  import bool_test_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND: result = x & y;
      OP_OR:  result = x | y;
      OP_XOR: result = x ^ y;
      OP_NOR: result = ~(x | y);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bool_sweep_checker.sv
// Exhaustive a/b sweep engine: drives a boolean unit, compares against bool_golden, and
// counts mismatches while capturing the first failing vector.
module bool_sweep_checker
  import bool_test_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SWEEP_BITS = 6,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned CNT_W      = 13
) (
  input logic                 clk,
  input logic                 rst_n,
  bool_sweep_checker_if.master bus
);

  localparam int unsigned             SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]        SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [SWEEP_BITS-1:0]   IDX_MAX     = '1;
  localparam logic [CNT_W-1:0]        CNT_MAX     = '1;

  state_e                state_q, state_d;
  logic [SWEEP_BITS-1:0] i_q, i_d, j_q, j_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [CNT_W-1:0]      err_q, err_d;
  logic [WIDTH-1:0]      fa_q, fa_d, fb_q, fb_d, fg_q, fg_d;
  op_e                   op_q, op_d;
  logic [WIDTH-1:0]      a_ext, b_ext, golden;
  logic                  accept, last_vec, mismatch;

  assign a_ext    = WIDTH'(i_q);
  assign b_ext    = WIDTH'(j_q);
  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_vec = (i_q == IDX_MAX) && (j_q == IDX_MAX);
  assign mismatch = bus.dut_out != golden;

  bool_golden #(.WIDTH(WIDTH)) u_golden (
    .x      (a_ext),
    .y      (b_ext),
    .op     (op_q),
    .result (golden)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = WAIT;
      WAIT:    if (settle_q == SETTLE_LAST) state_d = CHECK;
      CHECK:   state_d = last_vec ? DONE : WAIT;
      DONE:    if (bus.start) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    settle_d = settle_q;
    err_d    = err_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    fg_d     = fg_q;
    op_d     = op_q;
    if (accept) begin
      i_d      = '0;
      j_d      = '0;
      settle_d = '0;
      err_d    = '0;
      fa_d     = '0;
      fb_d     = '0;
      fg_d     = '0;
      op_d     = bus.op_sel;
    end else if (state_q == WAIT) begin
      settle_d = (settle_q == SETTLE_LAST) ? '0 : settle_q + 1'b1;
    end else if (state_q == CHECK) begin
      if (mismatch) begin
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        // err_q never returns to zero once counting, so zero means no capture yet
        if (err_q == '0) begin
          fa_d = a_ext;
          fb_d = b_ext;
          fg_d = bus.dut_out;
        end
      end
      if (!last_vec) begin
        if (j_q != IDX_MAX) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      fg_q     <= '0;
      op_q     <= OP_AND;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      fg_q     <= fg_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == WAIT) || (state_q == CHECK);
    bus.done = (state_q == DONE);
    bus.pass = (state_q == DONE) && (err_q == '0);
  end

  assign bus.a             = a_ext;
  assign bus.b             = b_ext;
  assign bus.err_count     = err_q;
  assign bus.first_err_a   = fa_q;
  assign bus.first_err_b   = fb_q;
  assign bus.first_err_got = fg_q;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Self-checking bench: table of full sweeps scored from a queue, plus abort/restart/saturation.
module tb_bool_sweep_checker;
  import bool_test_pkg::*;

  typedef enum logic [1:0] {M_OR, M_STUCK, M_XOR, M_INV} mode_e;

  typedef struct {
    mode_e       mode;
    op_e         op;
    int unsigned err;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] fg;
  } vec_t;

  typedef struct {
    int unsigned err;
    logic        pass;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] fg;
    int          cycles;
  } exp_t;

  localparam int FULL_CYC  = 4096 * 3;
  localparam int SMALL_CYC = 16 * 2;

  logic  clk = 1'b0;
  logic  rst_n;
  mode_e mode;
  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  vecs[5];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  bool_sweep_checker_if #(.WIDTH(32), .CNT_W(13)) bus ();
  bool_sweep_checker_if #(.WIDTH(8),  .CNT_W(4))  sbus ();

  bool_sweep_checker #(.WIDTH(32), .SWEEP_BITS(6), .SETTLE(2), .CNT_W(13)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bool_sweep_checker #(.WIDTH(8), .SWEEP_BITS(2), .SETTLE(1), .CNT_W(4)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Models of the unit under test
  always_comb begin
    case (mode)
      M_OR:    bus.dut_out = bus.a | bus.b;
      M_STUCK: bus.dut_out = (bus.a | bus.b) & ~32'h1;
      M_XOR:   bus.dut_out = bus.a ^ bus.b;
      M_INV:   bus.dut_out = ~(bus.a | bus.b);
      default: bus.dut_out = '0;
    endcase
  end

  assign sbus.dut_out = ~(sbus.a | sbus.b);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_main_idle(input string tag);
    check({tag, "_a"}, bus.a, 0);
    check({tag, "_b"}, bus.b, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_err"}, bus.err_count, 0);
    check({tag, "_fa"}, bus.first_err_a, 0);
    check({tag, "_fb"}, bus.first_err_b, 0);
    check({tag, "_fg"}, bus.first_err_got, 0);
  endtask

  // Start a sweep; optionally pulse start with a different op while busy at cycle poke_at.
  task automatic main_sweep(input op_e op, input int poke_at, output int cycles);
    @(negedge clk);
    bus.op_sel = op;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles    = 0;
    while (!bus.done && cycles < FULL_CYC + 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == poke_at) begin
        bus.start  = 1'b1;
        bus.op_sel = OP_AND;
      end else if (cycles == poke_at + 1) begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic score_main(input string tag, input int cycles);
    exp_t e;
    check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_cycles"}, cycles, e.cycles);
      check({tag, "_err"}, bus.err_count, e.err);
      check({tag, "_pass"}, bus.pass, e.pass);
      check({tag, "_fa"}, bus.first_err_a, e.fa);
      check({tag, "_fb"}, bus.first_err_b, e.fb);
      check({tag, "_fg"}, bus.first_err_got, e.fg);
    end
  endtask

  task automatic small_wait(output int cycles);
    cycles = 0;
    while (!sbus.done && cycles < SMALL_CYC + 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic score_small(input string tag, input int cycles);
    exp_t e;
    check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_done"}, sbus.done, 1);
      check({tag, "_cycles"}, cycles, e.cycles);
      check({tag, "_err"}, sbus.err_count, e.err);
      check({tag, "_pass"}, sbus.pass, e.pass);
      check({tag, "_fa"}, sbus.first_err_a, e.fa);
      check({tag, "_fb"}, sbus.first_err_b, e.fb);
      check({tag, "_fg"}, sbus.first_err_got, e.fg);
    end
  endtask

  initial begin
    int   cyc;
    exp_t e;

    vecs[0] = '{mode: M_OR,    op: OP_OR,  err: 0,    fa: 0, fb: 0, fg: 0};
    vecs[1] = '{mode: M_STUCK, op: OP_OR,  err: 3072, fa: 0, fb: 1, fg: 0};
    vecs[2] = '{mode: M_OR,    op: OP_AND, err: 4032, fa: 0, fb: 1, fg: 1};
    vecs[3] = '{mode: M_XOR,   op: OP_XOR, err: 0,    fa: 0, fb: 0, fg: 0};
    vecs[4] = '{mode: M_INV,   op: OP_NOR, err: 0,    fa: 0, fb: 0, fg: 0};

    rst_n       = 1'b0;
    mode        = M_OR;
    bus.start   = 1'b0;
    bus.op_sel  = OP_AND;
    sbus.start  = 1'b0;
    sbus.op_sel = OP_AND;

    repeat (3) @(posedge clk);
    #1;
    check_main_idle("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_main_idle("idle");
    check("small_idle_done", sbus.done, 0);
    check("small_idle_busy", sbus.busy, 0);

    foreach (vecs[k]) begin
      mode = vecs[k].mode;
      e = '{err: vecs[k].err, pass: (vecs[k].err == 0), fa: vecs[k].fa, fb: vecs[k].fb,
            fg: vecs[k].fg, cycles: FULL_CYC};
      exp_q.push_back(e);
      main_sweep(vecs[k].op, -1, cyc);
      score_main($sformatf("row%0d", k), cyc);
    end

    // Abort at vector 100 (a=1, b=36)
    mode = M_STUCK;
    @(negedge clk);
    bus.op_sel = OP_OR;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("abort_pre_busy", bus.busy, 1);
    check("abort_pre_a", bus.a, 1);
    check("abort_pre_b", bus.b, 36);
    check("abort_pre_err_nonzero", (bus.err_count != 0), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_main_idle("abort");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean pass with an ignored start (and op change) mid-sweep
    mode = M_OR;
    e = '{err: 0, pass: 1'b1, fa: 0, fb: 0, fg: 0, cycles: FULL_CYC};
    exp_q.push_back(e);
    main_sweep(OP_OR, 150, cyc);
    score_main("restart_ignored", cyc);

    // Saturation on the narrow instance, then restart directly from DONE
    e = '{err: 15, pass: 1'b0, fa: 0, fb: 0, fg: 32'hFF, cycles: SMALL_CYC};
    exp_q.push_back(e);
    @(negedge clk);
    sbus.op_sel = OP_OR;
    sbus.start  = 1'b1;
    @(posedge clk);
    #1;
    sbus.start = 1'b0;
    small_wait(cyc);
    score_small("sat", cyc);

    exp_q.push_back(e);
    @(negedge clk);
    sbus.start = 1'b1;
    @(posedge clk);
    #1;
    sbus.start = 1'b0;
    check("done_restart_done", sbus.done, 0);
    check("done_restart_busy", sbus.busy, 1);
    check("done_restart_err", sbus.err_count, 0);
    small_wait(cyc);
    score_small("sat2", cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
